// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl shared definitions: stage indices, FSM states, reset level.
// Included by pipe_ctrl, pipe_ctrl_if users and pipe_ctrl_drain_timer.
package pipe_ctrl_pkg;

  localparam int STAGE_IF  = 0;
  localparam int STAGE_ID  = 1;
  localparam int STAGE_EX  = 2;
  localparam int STAGE_MEM = 3;
  localparam int STAGE_WB  = 4;

  localparam logic RST_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    PIPE_RUN      = 2'd0,
    PIPE_DRAIN    = 2'd1,
    PIPE_REDIRECT = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline <-> controller bundle; master = pipeline, slave = pipe_ctrl.
// PIPE_CTRL_PERF_EN adds the performance counter outputs.
interface pipe_ctrl_if #(
  parameter int STAGES = 5,
  parameter int XLEN   = 32
);

  logic [STAGES-1:0] stall_req_i;
  logic              mem_busy_i;
  logic              branch_i;
  logic [XLEN-1:0]   branch_target_i;
  logic              trap_i;
  logic [XLEN-1:0]   trap_vec_i;
  logic [STAGES-1:0] stall_o;
  logic [STAGES-1:0] flush_o;
  logic              redirect_o;
  logic [XLEN-1:0]   redirect_pc_o;
  logic              timeout_o;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc_o;
  logic [31:0] perf_flush_cnt_o;

  modport master (
    output stall_req_i, mem_busy_i, branch_i,
    output branch_target_i, trap_i, trap_vec_i,
    input  stall_o, flush_o, redirect_o,
    input  redirect_pc_o, timeout_o,
    input  perf_stall_cyc_o, perf_flush_cnt_o
  );

  modport slave (
    input  stall_req_i, mem_busy_i, branch_i,
    input  branch_target_i, trap_i, trap_vec_i,
    output stall_o, flush_o, redirect_o,
    output redirect_pc_o, timeout_o,
    output perf_stall_cyc_o, perf_flush_cnt_o
  );
`else
  modport master (
    output stall_req_i, mem_busy_i, branch_i,
    output branch_target_i, trap_i, trap_vec_i,
    input  stall_o, flush_o, redirect_o,
    input  redirect_pc_o, timeout_o
  );

  modport slave (
    input  stall_req_i, mem_busy_i, branch_i,
    input  branch_target_i, trap_i, trap_vec_i,
    output stall_o, flush_o, redirect_o,
    output redirect_pc_o, timeout_o
  );
`endif

endinterface

// File: rtl/pipe_ctrl_drain_timer.sv
// Drain timeout counter; expired fires on the busy cycle that
// would bring the count to its all-ones value.
module pipe_ctrl_drain_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic busy,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LAST =
    {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt + TIMEOUT_W'(1);
    end
  end

  assign expired = busy && (cnt == LAST);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush/redirect controller for the 5-stage pipeline.
// Optional macro PIPE_CTRL_PERF_EN adds stall/flush perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES    = 5,
  parameter int XLEN      = 32,
  parameter int TIMEOUT_W = 8
) (
  input logic     clk,
  input logic     rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [STAGES-1:0] STALL_IF  = STAGES'(1);
  localparam logic [STAGES-1:0] FLUSH_ALL = ~STAGES'(1);
  localparam logic [STAGES-1:0] FLUSH_BR  =
    STAGES'((1 << STAGE_ID) | (1 << STAGE_EX));

  pipe_state_t       state;
  logic [XLEN-1:0]   vec;
  logic              timeout;
  logic [STAGES-1:0] s;
  logic [STAGES-1:0] held;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] flush;
  logic              redir;
  logic [XLEN-1:0]   pc;
  logic              br_ok;
  logic              trap_go;
  logic              drain_busy;
  logic              expired;

  // held[j]: some stage at or beyond j is blocked
  always_comb begin
    s = bus.stall_req_i |
        (STAGES'(bus.mem_busy_i) << STAGE_MEM);
    held = '0;
    for (int j = 0; j < STAGES; j++) begin
      held[j] = |(s >> j);
    end
  end

  assign br_ok      = bus.branch_i && !held[STAGE_EX];
  assign trap_go    = (state == PIPE_RUN) && bus.trap_i;
  assign drain_busy = (state == PIPE_DRAIN) && bus.mem_busy_i;

  pipe_ctrl_drain_timer #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (trap_go),
    .busy   (drain_busy),
    .expired(expired)
  );

  always_comb begin
    stall = '0;
    flush = '0;
    redir = 1'b0;
    pc    = '0;
    if (rst != RST_ACTIVE) begin
      unique case (state)
        PIPE_RUN: begin
          if (bus.trap_i) begin
            stall = STALL_IF;
            flush = FLUSH_ALL;
          end else if (br_ok) begin
            flush = FLUSH_BR;
            redir = 1'b1;
            pc    = bus.branch_target_i;
          end else begin
            stall = held;
            for (int j = 1; j < STAGES; j++) begin
              flush[j] = s[j-1] & ~held[j];
            end
          end
        end
        PIPE_DRAIN: begin
          stall = STALL_IF;
          flush = FLUSH_ALL;
        end
        PIPE_REDIRECT: begin
          flush = FLUSH_ALL;
          redir = 1'b1;
          pc    = vec;
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_o       = stall;
  assign bus.flush_o       = flush;
  assign bus.redirect_o    = redir;
  assign bus.redirect_pc_o = pc;
  assign bus.timeout_o     = timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      state   <= PIPE_RUN;
      vec     <= '0;
      timeout <= 1'b0;
    end else begin
      unique case (state)
        PIPE_RUN: begin
          if (bus.trap_i) begin
            state <= PIPE_DRAIN;
            vec   <= bus.trap_vec_i;
          end
        end
        PIPE_DRAIN: begin
          if (!bus.mem_busy_i) begin
            state <= PIPE_REDIRECT;
          end else if (expired) begin
            state   <= PIPE_REDIRECT;
            timeout <= 1'b1;
          end
        end
        PIPE_REDIRECT: state <= PIPE_RUN;
        default:       state <= PIPE_RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] pstall;
  logic [31:0] pflush;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      pstall <= '0;
      pflush <= '0;
    end else begin
      if (stall[STAGE_IF]) pstall <= pstall + 32'd1;
      if (trap_go || ((state == PIPE_RUN) && br_ok))
        pflush <= pflush + 32'd1;
    end
  end

  assign bus.perf_stall_cyc_o = pstall;
  assign bus.perf_flush_cnt_o = pflush;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: vector table, directed sequences and
// randomized traffic against a behavioural model (TIMEOUT_W=4).
module tb_pipe_ctrl;

  localparam int MAXC = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int redir_seen = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.STAGES(5), .XLEN(32)) bus ();

  pipe_ctrl #(
    .STAGES(5), .XLEN(32), .TIMEOUT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // model: 0 running, 1 draining, 2 redirecting to trap vector
  int          m_phase, n_phase;
  int          m_drained, n_drained;
  bit          m_to, n_to;
  logic [31:0] m_vec, n_vec;
  logic [4:0]  e_stall, e_flush;
  logic        e_redir;
  logic [31:0] e_pc;

  typedef struct {
    logic [4:0]  sr;
    logic        mb;
    logic        br;
    logic [31:0] bt;
    logic [4:0]  es;
    logic [4:0]  ef;
    logic        er;
    logic [31:0] ep;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase   = 0;
    m_drained = 0;
    m_to      = 1'b0;
    m_vec     = '0;
  endfunction

  function automatic void model_eval(
    input logic [4:0] sr, input logic mb, input logic br,
    input logic [31:0] bt, input logic tr, input logic [31:0] tv);
    logic [4:0] s;
    int k;
    n_phase = m_phase; n_drained = m_drained;
    n_to = m_to; n_vec = m_vec;
    e_stall = '0; e_flush = '0; e_redir = 1'b0; e_pc = '0;
    s = sr | {1'b0, mb, 3'b000};
    k = -1;
    for (int i = 0; i < 5; i++) if (s[i]) k = i;
    case (m_phase)
      0: begin
        if (tr) begin
          e_stall = 5'b00001; e_flush = 5'b11110;
          n_phase = 1; n_drained = 0; n_vec = tv;
        end else if (br && k < 2) begin
          e_redir = 1'b1; e_pc = bt; e_flush = 5'b00110;
        end else if (k >= 0) begin
          e_stall = 5'((1 << (k + 1)) - 1);
          if (k < 4) e_flush = 5'(1 << (k + 1));
        end
      end
      1: begin
        e_stall = 5'b00001; e_flush = 5'b11110;
        if (!mb) n_phase = 2;
        else begin
          n_drained = m_drained + 1;
          if (n_drained == MAXC) begin
            n_phase = 2; n_to = 1'b1;
          end
        end
      end
      default: begin
        e_redir = 1'b1; e_pc = m_vec; e_flush = 5'b11110;
        n_phase = 0;
      end
    endcase
  endfunction

  task automatic drive(input logic [4:0] sr, input logic mb,
                       input logic br, input logic [31:0] bt,
                       input logic tr, input logic [31:0] tv);
    bus.stall_req_i = sr;
    bus.mem_busy_i = mb;
    bus.branch_i = br;
    bus.branch_target_i = bt;
    bus.trap_i = tr;
    bus.trap_vec_i = tv;
  endtask

  // called at posedge+1; checks at negedge, returns at next posedge+1
  task automatic apply(input logic [4:0] sr, input logic mb,
                       input logic br, input logic [31:0] bt,
                       input logic tr, input logic [31:0] tv);
    drive(sr, mb, br, bt, tr, tv);
    model_eval(sr, mb, br, bt, tr, tv);
    @(negedge clk);
    chk("stall", 32'(bus.stall_o), 32'(e_stall));
    chk("flush", 32'(bus.flush_o), 32'(e_flush));
    chk("redirect", 32'(bus.redirect_o), 32'(e_redir));
    chk("redirect_pc", bus.redirect_pc_o, e_pc);
    chk("timeout", 32'(bus.timeout_o), 32'(m_to));
    if (bus.redirect_o === 1'b1) redir_seen++;
    @(posedge clk);
    m_phase = n_phase; m_drained = n_drained;
    m_to = n_to; m_vec = n_vec;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(5'h1f, 1'b1, 1'b1, 32'h44, 1'b0, 32'h0);
    #1;
    chk("rst_stall", 32'(bus.stall_o), 32'h0);
    chk("rst_flush", 32'(bus.flush_o), 32'h0);
    chk("rst_redirect", 32'(bus.redirect_o), 32'h0);
    chk("rst_pc", bus.redirect_pc_o, 32'h0);
    chk("rst_timeout", 32'(bus.timeout_o), 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    drive(5'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, n, at;

    tbl[0] = '{5'b00000, 0, 0, 32'h0,   5'b00000, 5'b00000, 0, 32'h0};
    tbl[1] = '{5'b00001, 0, 0, 32'h0,   5'b00001, 5'b00010, 0, 32'h0};
    tbl[2] = '{5'b00100, 0, 0, 32'h0,   5'b00111, 5'b01000, 0, 32'h0};
    tbl[3] = '{5'b10000, 0, 0, 32'h0,   5'b11111, 5'b00000, 0, 32'h0};
    tbl[4] = '{5'b00000, 1, 0, 32'h0,   5'b01111, 5'b10000, 0, 32'h0};
    tbl[5] = '{5'b00010, 0, 1, 32'h100, 5'b00000, 5'b00110, 1, 32'h100};
    tbl[6] = '{5'b00000, 1, 1, 32'h100, 5'b01111, 5'b10000, 0, 32'h0};
    tbl[7] = '{5'b00101, 0, 1, 32'h200, 5'b00111, 5'b01000, 0, 32'h0};
    tbl[8] = '{5'b00000, 0, 1, 32'h200, 5'b00000, 5'b00110, 1, 32'h200};
    tbl[9] = '{5'b01010, 0, 0, 32'h0,   5'b01111, 5'b10000, 0, 32'h0};

    model_reset();
    do_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].sr, tbl[i].mb, tbl[i].br, tbl[i].bt, 1'b0, 32'h0);
      @(negedge clk);
      chk($sformatf("tbl%0d_stall", i), 32'(bus.stall_o), 32'(tbl[i].es));
      chk($sformatf("tbl%0d_flush", i), 32'(bus.flush_o), 32'(tbl[i].ef));
      chk($sformatf("tbl%0d_redir", i), 32'(bus.redirect_o), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_pc", i), bus.redirect_pc_o, tbl[i].ep);
      @(posedge clk);
      #1;
    end

    // ID-stage stall held three cycles, then released
    for (int i = 0; i < 3; i++) begin
      apply(5'b00100, 0, 0, 0, 0, 0);
    end
    apply(5'b00000, 0, 0, 0, 0, 0);

    // branch waits behind mem_busy and goes the cycle it drops
    r0 = redir_seen;
    apply(5'b00000, 1, 1, 32'h300, 0, 0);
    apply(5'b00000, 1, 1, 32'h300, 0, 0);
    chk("br_blocked", 32'(redir_seen - r0), 32'd0);
    apply(5'b00000, 0, 1, 32'h300, 0, 0);
    chk("br_after_busy", 32'(redir_seen - r0), 32'd1);

    // trap beats branch; drain four busy cycles; one redirect
    r0 = redir_seen;
    at = -1;
    for (int i = 0; i < 9; i++) begin
      n = redir_seen;
      apply(5'b00000, (i < 4), (i == 0), 32'h500,
            (i == 0 || i == 5), 32'h8000_0000);
      if (redir_seen != n && at < 0) at = i;
    end
    chk("trap_redir_count", 32'(redir_seen - r0), 32'd1);
    chk("trap_redir_cycle", 32'(at), 32'd5);
    chk("trap_no_timeout", 32'(bus.timeout_o), 32'd0);

    // drain timeout with memory stuck busy
    apply(5'b00000, 1, 0, 0, 1, 32'h0000_a000);
    r0 = redir_seen;
    n = 0;
    while (redir_seen == r0 && n < 30) begin
      apply(5'b00000, 1, 0, 0, 0, 0);
      n++;
    end
    chk("drain_len", 32'(n - 1), 32'(MAXC));
    for (int i = 0; i < 3; i++) apply(5'b00000, 0, 0, 0, 1'b0, 0);
    chk("timeout_sticky", 32'(bus.timeout_o), 32'd1);
    do_reset();

    // asynchronous reset in the middle of a drain
    apply(5'b00000, 1, 0, 0, 1, 32'h0000_1234);
    apply(5'b00000, 1, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_stall", 32'(bus.stall_o), 32'h0);
    chk("async_flush", 32'(bus.flush_o), 32'h0);
    chk("async_redir", 32'(bus.redirect_o), 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    r0 = redir_seen;
    for (int i = 0; i < 4; i++) apply(5'b00000, 0, 0, 0, 0, 0);
    chk("async_no_redir", 32'(redir_seen - r0), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] sr;
      sr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
      apply(sr, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), $urandom,
            ($urandom_range(0, 15) == 0), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush/redirect controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Resolves per-stage stall requests into hold/bubble controls for the pipeline registers.
- Redirects the PC on taken branches.
- Sequences trap entry: flush, drain outstanding data-memory access, redirect to trap vector.

Parameters:
- STAGES, 5, number of pipeline stages; index 0=IF .. 4=WB.
- XLEN, 32, PC width.
- TIMEOUT_W, 8, width of the drain timeout counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; asynchronous, active-low (asserted at 0).
- stall_req_i  in  STAGES  bit k = stage k cannot accept/advance this cycle.
- mem_busy_i  in  1  data-memory access outstanding; OR-ed into stall_req_i[3].
- branch_i  in  1  taken branch/jump resolved in EX (stage 2).
- branch_target_i  in  XLEN  branch destination.
- trap_i  in  1  exception raised by the instruction in MEM (stage 3).
- trap_vec_i  in  XLEN  trap handler address.
- stall_o  out  STAGES  bit k = register feeding stage k holds at next edge.
- flush_o  out  STAGES  bit k = register feeding stage k loads its reset/NOP value at next edge.
- redirect_o  out  1  PC loads redirect_pc_o at next edge.
- redirect_pc_o  out  XLEN  redirect target.
- timeout_o  out  1  sticky: a drain timed out.

Behaviour:
- Reset, asynchronous on rst=0:
  - state=RUN, drain counter=0, latched vector=0, timeout_o=0.
  - Combinational outputs then read as idle: stall_o=0, flush_o=0, redirect_o=0, redirect_pc_o=0.
- FSM states: RUN, DRAIN, REDIRECT. Outputs are combinational from state and inputs; state, counter and vector are registered.
- RUN, stall resolution:
  - s = stall_req_i | (mem_busy_i<<3); k = highest set bit of s.
  - stall_o[j]=1 for all j<=k.
  - flush_o[k+1]=1 if k<STAGES-1, inserting one bubble.
  - s=0: no stall, no flush.
- RUN, taken branch (branch_i=1, no trap):
  - k>=2: branch ignored this cycle; EX is held and re-presents the branch.
  - k<2 or no stall: redirect_o=1 and redirect_pc_o=branch_target_i in the same cycle.
  - flush_o[1]=flush_o[2]=1; stall_o=0, so the branch overrides IF/ID stall requests.
- RUN, trap (trap_i=1):
  - Highest priority; overrides branch and all stalls.
  - Same cycle: flush_o[4:1]=1111, stall_o[0]=1.
  - Latch trap_vec_i; next state DRAIN, counter cleared.
- DRAIN:
  - stall_o[0]=1, flush_o[4:1]=1111 every cycle; branch_i, trap_i and stall_req_i are ignored.
  - Counter increments each cycle while mem_busy_i=1.
  - mem_busy_i=0 -> REDIRECT.
  - Counter reaches 2^TIMEOUT_W-1 -> REDIRECT and timeout_o<=1 (held until reset).
  - mem_busy_i=0 on the trap cycle itself -> DRAIN still lasts exactly one cycle.
- REDIRECT (one cycle):
  - redirect_o=1, redirect_pc_o=latched vector, flush_o[4:1]=1111, stall_o=0.
  - Next state RUN. trap_i here is ignored.
- Reset asserted mid-DRAIN/REDIRECT: immediate return to RUN; pending redirect is discarded.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cyc_o (32) and perf_flush_cnt_o (32); both reset to 0 and wrap at 2^32.
  - perf_stall_cyc_o increments on every cycle with stall_o[0]=1.
  - perf_flush_cnt_o increments once per accepted branch redirect and once per trap entry.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared defines file:
  - stage index constants (STAGE_IF..STAGE_WB).
  - FSM state encodings (PIPE_RUN, PIPE_DRAIN, PIPE_REDIRECT).
  - reset-level constant for the active-low reset.
- One sub-module: pipe_ctrl_drain_timer. Holds the TIMEOUT_W counter; ports: clear, busy, expired.

Test Plan:
- stall_req_i=00100 for 3 cycles -> stall_o=00111, flush_o=01000 each cycle; then both return to 0.
- branch_i=1, target 0x0000_0100, stall_req_i=00010 -> same cycle redirect_o=1, redirect_pc_o=0x100, flush_o=00110, stall_o=0.
- branch_i=1 with mem_busy_i=1 -> redirect_o=0, stall_o=01111, flush_o=10000; branch honoured in the first cycle after mem_busy_i falls.
- trap_i=1 with branch_i=1, trap_vec_i=0x8000_0000, mem_busy_i=1 for 4 cycles -> flush_o=11110 in the trap and DRAIN cycles; redirect_o=1 with PC 0x8000_0000 exactly once, on the cycle after mem_busy_i falls; timeout_o=0.
- trap with mem_busy_i stuck at 1, TIMEOUT_W=4 -> REDIRECT after 15 DRAIN cycles; timeout_o=1, sticky until rst=0.
- rst=0 pulsed mid-DRAIN (asynchronous, between clock edges) -> outputs idle immediately; no redirect after release.
